inst_fetch: RTL

// - Fetch stage, directly upstream of CtrlUnit: supplies `inst` plus its PC to decode.
// - Issues word reads to instruction memory and buffers in-order responses in a small FIFO.
// - Presents instructions on a valid/ready handshake; redirects on taken branch/jump and discards stale fetches.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/inst_fetch_fifo.sv | 64 ++++++
 rtl/inst_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults.
// Imported by the fetch stage and its buffer.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, inst} entries for decode.
// Flush has priority over push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: credit-limited word reads to imem, in-order response buffering,
// valid/ready delivery to decode, and redirect with stale-response dropping.
module inst_fetch #(
    parameter int unsigned            XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]        RESET_PC = riscv_pkg::RESET_PC,
    parameter int unsigned            DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import riscv_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] pcq_mem [DEPTH];
    logic [AW-1:0]   pcq_wr;
    logic [AW-1:0]   pcq_rd;
    logic            accept;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    fifo_head;
    logic            unused_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Credits: outstanding reads plus buffered entries never exceed DEPTH,
    // so every response is guaranteed a buffer slot.
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: imem_req_valid = !redirect_valid &&
                     (({1'b0, in_flight} + {1'b0, fifo_count}) < (CW + 1)'(DEPTH));
            default: state_d = BOOT;
        endcase
    end

    assign accept    = imem_req_valid && imem_req_ready;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (accept) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({accept, imem_rsp_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // On redirect every read still outstanding is stale, including any already
    // marked for dropping, so the drop count becomes the surviving in-flight total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= in_flight - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcq_wr <= '0;
            pcq_rd <= '0;
        end else begin
            if (accept) begin
                pcq_wr <= pcq_wr + 1'b1;
            end
            if (imem_rsp_valid) begin
                pcq_rd <= pcq_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
    end

    assign push_entry = '{pc: pcq_mem[pcq_rd], inst: imem_rsp_data};
    assign fifo_push  = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid  = !fifo_empty;
    assign inst        = fifo_head.inst;
    assign inst_pc     = fifo_head.pc;
    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

endmodule
